// File: rtl/cuckoo_pkg.sv
// Shared constants, table selects and lookup FSM states for the cuckoo-hash engines.
// The lookup engine's optional delete-on-hit path is enabled by CUCKOO_DELETE_EN.
package cuckoo_pkg;

    localparam int unsigned TABLE_SIZE = 20;
    localparam int unsigned KEY_W      = 32;
    localparam int unsigned IDX_W      = 5;

    localparam logic TBL1 = 1'b0;
    localparam logic TBL2 = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StRd1,
        StCmp1,
        StRd2,
        StCmp2,
        StClr,
        StResp
    } lookup_state_e;

endpackage

// File: rtl/cuckoo_hash_idx.sv
// Key to slot-index hashing, shared by the insert and lookup engines so both sides agree.
// h1 = key mod TABLE_SIZE, h2 = (key / TABLE_SIZE) mod TABLE_SIZE, unsigned.
module cuckoo_hash_idx
    import cuckoo_pkg::*;
(
    input  logic [KEY_W-1:0] i_key,
    output logic [IDX_W-1:0] o_h1,
    output logic [IDX_W-1:0] o_h2
);

    localparam logic [KEY_W-1:0] DIV = KEY_W'(TABLE_SIZE);

    assign o_h1 = IDX_W'(i_key % DIV);
    assign o_h2 = IDX_W'((i_key / DIV) % DIV);

endmodule

// File: rtl/cuckoo_lookup.sv
// Cuckoo-hash lookup engine: probes table1 then table2 through a one-cycle-latency read port.
// Define CUCKOO_DELETE_EN to honour req_del (clear the filled bit of a hit before responding).
module cuckoo_lookup
    import cuckoo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] req_key,
    input  logic             req_del,
    output logic             t_rd_en,
    output logic             t_rd_sel,
    output logic [IDX_W-1:0] t_rd_idx,
    input  logic [KEY_W-1:0] t_rd_data,
    input  logic             t_rd_filled,
    output logic             t_clr_en,
    output logic             t_clr_sel,
    output logic [IDX_W-1:0] t_clr_idx,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic             rsp_table,
    output logic [IDX_W-1:0] rsp_idx
);

    lookup_state_e    r_state;
    lookup_state_e    r_state_d;
    lookup_state_e    w_hit_st;

    logic [KEY_W-1:0] r_key;
    logic [IDX_W-1:0] r_h1;
    logic [IDX_W-1:0] r_h2;
    logic             r_hit;
    logic             r_tbl;
    logic [IDX_W-1:0] r_idx;

    logic [IDX_W-1:0] w_h1;
    logic [IDX_W-1:0] w_h2;
    logic             w_accept;
    logic             w_match;
    logic             w_rec;
    logic             w_rec_tbl;

    cuckoo_hash_idx u_hash (
        .i_key (req_key),
        .o_h1  (w_h1),
        .o_h2  (w_h2)
    );

    assign w_accept = req_valid && req_ready;
    assign w_match  = t_rd_filled && (t_rd_data == r_key);

`ifdef CUCKOO_DELETE_EN
    logic r_del;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_del <= 1'b0;
        end else if (w_accept) begin
            r_del <= req_del;
        end
    end

    assign w_hit_st  = r_del ? StClr : StResp;
    assign t_clr_en  = (r_state == StClr);
    assign t_clr_sel = t_clr_en & r_tbl;
    assign t_clr_idx = t_clr_en ? r_idx : '0;
`else
    logic w_unused_del;

    assign w_unused_del = req_del;
    assign w_hit_st     = StResp;
    assign t_clr_en     = 1'b0;
    assign t_clr_sel    = 1'b0;
    assign t_clr_idx    = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= r_state_d;
        end
    end

    // Read data is valid in the CMP state that follows each RD state.
    always_comb begin
        r_state_d = r_state;
        w_rec     = 1'b0;
        w_rec_tbl = TBL1;
        case (r_state)
            StIdle: begin
                if (w_accept) r_state_d = StRd1;
            end
            StRd1: r_state_d = StCmp1;
            StCmp1: begin
                if (w_match) begin
                    w_rec     = 1'b1;
                    w_rec_tbl = TBL1;
                    r_state_d = w_hit_st;
                end else begin
                    r_state_d = StRd2;
                end
            end
            StRd2: r_state_d = StCmp2;
            StCmp2: begin
                if (w_match) begin
                    w_rec     = 1'b1;
                    w_rec_tbl = TBL2;
                    r_state_d = w_hit_st;
                end else begin
                    r_state_d = StResp;
                end
            end
            StClr: r_state_d = StResp;
            StResp: begin
                if (rsp_ready) r_state_d = StIdle;
            end
            default: r_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key <= '0;
            r_h1  <= '0;
            r_h2  <= '0;
            r_hit <= 1'b0;
            r_tbl <= TBL1;
            r_idx <= '0;
        end else if (w_accept) begin
            r_key <= req_key;
            r_h1  <= w_h1;
            r_h2  <= w_h2;
            r_hit <= 1'b0;
            r_tbl <= TBL1;
            r_idx <= '0;
        end else if (w_rec) begin
            r_hit <= 1'b1;
            r_tbl <= w_rec_tbl;
            r_idx <= (w_rec_tbl == TBL2) ? r_h2 : r_h1;
        end
    end

    assign req_ready = (r_state == StIdle);

    assign t_rd_en  = (r_state == StRd1) || (r_state == StRd2);
    assign t_rd_sel = (r_state == StRd2);
    assign t_rd_idx = (r_state == StRd1) ? r_h1 :
                      (r_state == StRd2) ? r_h2 : '0;

    // Response fields are masked outside RESP so idle outputs read as zero.
    assign rsp_valid = (r_state == StResp);
    assign rsp_hit   = rsp_valid & r_hit;
    assign rsp_table = rsp_valid & r_tbl;
    assign rsp_idx   = rsp_valid ? r_idx : '0;

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Self-checking bench for cuckoo_lookup: behavioural table/lookup model, directed then random.
// Works with or without CUCKOO_DELETE_EN defined.
module tb_cuckoo_lookup;
    import cuckoo_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [KEY_W-1:0] req_key = '0;
    logic             req_del = 1'b0;
    logic             t_rd_en;
    logic             t_rd_sel;
    logic [IDX_W-1:0] t_rd_idx;
    logic [KEY_W-1:0] t_rd_data;
    logic             t_rd_filled;
    logic             t_clr_en;
    logic             t_clr_sel;
    logic [IDX_W-1:0] t_clr_idx;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic             rsp_hit;
    logic             rsp_table;
    logic [IDX_W-1:0] rsp_idx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cuckoo_lookup dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_key     (req_key),
        .req_del     (req_del),
        .t_rd_en     (t_rd_en),
        .t_rd_sel    (t_rd_sel),
        .t_rd_idx    (t_rd_idx),
        .t_rd_data   (t_rd_data),
        .t_rd_filled (t_rd_filled),
        .t_clr_en    (t_clr_en),
        .t_clr_sel   (t_clr_sel),
        .t_clr_idx   (t_clr_idx),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_hit     (rsp_hit),
        .rsp_table   (rsp_table),
        .rsp_idx     (rsp_idx)
    );

    // Table contents, written only by the stimulus process.
    logic [31:0] m_data [2][20];
    bit          m_fill [2][20];

    // Read port model plus logs of every read and clear the DUT issues.
    int          rd_count  = 0;
    int          clr_count = 0;
    logic        rd_sel_log [1024];
    logic [4:0]  rd_idx_log [1024];
    logic        clr_sel_l;
    logic [4:0]  clr_idx_l;

    always @(posedge clk) begin
        if (t_rd_en && (t_rd_idx < 5'd20)) begin
            t_rd_data   <= m_data[t_rd_sel][t_rd_idx];
            t_rd_filled <= m_fill[t_rd_sel][t_rd_idx];
        end else begin
            t_rd_data   <= $urandom;
            t_rd_filled <= 1'b0;
        end
        if (t_rd_en) begin
            rd_sel_log[rd_count % 1024] <= t_rd_sel;
            rd_idx_log[rd_count % 1024] <= t_rd_idx;
            rd_count <= rd_count + 1;
        end
        if (t_clr_en) begin
            clr_sel_l <= t_clr_sel;
            clr_idx_l <= t_clr_idx;
            clr_count <= clr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic lookup(input logic [31:0] key, input bit del, input int bp, input string tag);
        logic [4:0] h1, h2, e_idx;
        bit         e_hit, e_tbl, seen;
        int         e_reads, e_clr, e_lat, r0, c0, n;

        // Reference: probe table1 then table2 by the hash rules.
        h1 = 5'(key % 32'd20);
        h2 = 5'((key / 32'd20) % 32'd20);
        if (m_fill[0][h1] && m_data[0][h1] == key) begin
            e_hit = 1; e_tbl = 0; e_idx = h1; e_reads = 1;
        end else if (m_fill[1][h2] && m_data[1][h2] == key) begin
            e_hit = 1; e_tbl = 1; e_idx = h2; e_reads = 2;
        end else begin
            e_hit = 0; e_tbl = 0; e_idx = 0; e_reads = 2;
        end
        e_clr = 0;
`ifdef CUCKOO_DELETE_EN
        if (del && e_hit) e_clr = 1;
`endif
        e_lat = ((e_reads == 1) ? 3 : 5) + e_clr;

        @(negedge clk);
        check({tag, "/req_ready_idle"}, req_ready, 1);
        req_valid = 1'b1;
        req_key   = key;
        req_del   = del;
        r0 = rd_count;
        c0 = clr_count;
        @(posedge clk);
        #1;
        // Junk request held while busy must be ignored.
        req_key = $urandom;
        req_del = 1'($urandom);
        if (bp > 0) rsp_ready = 1'b0;

        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            n++;
            seen = rsp_valid;
        end
        req_valid = 1'b0;
        check({tag, "/latency"}, n, e_lat);
        if (!seen) begin
            pulse_reset();
            return;
        end
        check({tag, "/req_ready_busy"}, req_ready, 0);
        check({tag, "/rsp_hit"}, rsp_hit, e_hit);
        check({tag, "/rsp_table"}, rsp_table, e_tbl);
        check({tag, "/rsp_idx"}, rsp_idx, e_idx);

        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check({tag, "/bp_valid"}, rsp_valid, 1);
            check({tag, "/bp_rsp"}, {rsp_hit, rsp_table, rsp_idx}, {e_hit, e_tbl, e_idx});
            check({tag, "/bp_req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "/rsp_done"}, rsp_valid, 0);

        check({tag, "/reads"}, rd_count - r0, e_reads);
        if (rd_count - r0 == e_reads) begin
            check({tag, "/rd0"}, {rd_sel_log[r0 % 1024], rd_idx_log[r0 % 1024]}, {1'b0, h1});
            if (e_reads == 2)
                check({tag, "/rd1"}, {rd_sel_log[(r0 + 1) % 1024], rd_idx_log[(r0 + 1) % 1024]},
                      {1'b1, h2});
        end
        check({tag, "/clears"}, clr_count - c0, e_clr);
        if (e_clr == 1 && clr_count - c0 == 1) begin
            check({tag, "/clr_at"}, {clr_sel_l, clr_idx_l}, {e_tbl, e_idx});
            m_fill[e_tbl][e_idx] = 0;
        end
    endtask

    initial begin
        int r0, c0;
        bit bad;
        logic [31:0] k;

        for (int t = 0; t < 2; t++)
            for (int s = 0; s < 20; s++) begin
                m_data[t][s] = '0;
                m_fill[t][s] = 0;
            end

        #1;
        check("reset/req_ready", req_ready, 1);
        check("reset/outs", {t_rd_en, t_rd_sel, t_rd_idx, t_clr_en, t_clr_sel, t_clr_idx,
                             rsp_valid, rsp_hit, rsp_table, rsp_idx}, 0);
        #11 reset = 1'b1;

        m_data[0][18] = 38; m_fill[0][18] = 1;
        lookup(38, 0, 0, "t1_hit_38");
        m_data[0][4] = 24; m_fill[0][4] = 1;
        m_data[1][4] = 84; m_fill[1][4] = 1;
        lookup(84, 0, 0, "t2_hit_84");
        lookup(93, 0, 0, "miss_93");
        m_data[0][16] = 76; m_fill[0][16] = 0;
        lookup(76, 0, 0, "unfilled_76");
        m_data[0][0] = 0; m_fill[0][0] = 0;
        m_data[1][0] = 0; m_fill[1][0] = 1;
        lookup(0, 0, 0, "key0");
        lookup(38, 0, 4, "bp_38");
        lookup(84, 0, 0, "b2b_84");
        lookup(38, 1, 0, "del_38");
        lookup(38, 0, 0, "after_del_38");

        // Asynchronous reset while the engine sits in CMP1.
        m_data[0][18] = 38; m_fill[0][18] = 1;
        @(negedge clk);
        req_valid = 1'b1; req_key = 38; req_del = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_mid/req_ready", req_ready, 1);
        check("rst_mid/outs", {t_rd_en, t_rd_sel, t_rd_idx, t_clr_en, t_clr_sel, t_clr_idx,
                               rsp_valid, rsp_hit, rsp_table, rsp_idx}, 0);
        #1 reset = 1'b1;
        r0 = rd_count;
        c0 = clr_count;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad = 1;
        end
        check("rst_mid/no_rsp", bad, 0);
        check("rst_mid/no_activity", {rd_count - r0, clr_count - c0}, 0);

        // Randomised tables and lookups against the model.
        for (int s = 0; s < 20; s++) begin
            m_data[0][s] = s + 20 * $urandom_range(0, 39);
            m_fill[0][s] = 1'($urandom);
            m_data[1][s] = 20 * s + $urandom_range(0, 19) + 400 * $urandom_range(0, 1);
            m_fill[1][s] = 1'($urandom);
        end
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: k = m_data[0][$urandom_range(0, 19)];
                1: k = m_data[1][$urandom_range(0, 19)];
                2: k = $urandom;
                default: k = $urandom_range(0, 799);
            endcase
            lookup(k, $urandom_range(0, 3) == 0, $urandom_range(0, 2), "rand");
        end

`ifndef CUCKOO_DELETE_EN
        check("no_clear_without_delete", clr_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
